router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
- Packet-reception controller for the 1x3 router.
- Sequences each incoming packet: header address decode, first-byte load (header), payload load, parity byte load, parity check.
- Stalls on destination FIFO full or non-empty.
- Drives the write-enable request and state strobes used by the synchronizer and the register/parity block. Sits between the input interface and the synchronizer/FIFOs.

Parameters:
none (state encoding internal, 3 bits; address field fixed at data_in[1:0], address 3 invalid)

Ports:
clock  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
pkt_valid  input  1  high while header/payload bytes are on data_in; falls with parity byte
data_in  input  2  header address field (data_in[1:0]); sampled only in DECODE_ADDRESS
fifo_full  input  1  full flag of the currently selected FIFO (from synchronizer)
fifo_empty_0  input  1  FIFO 0 empty
fifo_empty_1  input  1  FIFO 1 empty
fifo_empty_2  input  1  FIFO 2 empty
soft_reset_0  input  1  timeout reset, port 0
soft_reset_1  input  1  timeout reset, port 1
soft_reset_2  input  1  timeout reset, port 2
parity_done  input  1  register block has captured parity byte
low_pkt_valid  input  1  pkt_valid fell while FIFO was full (parity byte held in register block)
detect_add  output  1  in DECODE_ADDRESS
lfd_state  output  1  in LOAD_FIRST_DATA
ld_state  output  1  in LOAD_DATA
laf_state  output  1  in LOAD_AFTER_FULL
full_state  output  1  in FIFO_FULL_STATE
write_enb_reg  output  1  request FIFO write this cycle
rst_int_reg  output  1  in CHECK_PARITY_ERROR; clears internal parity registers
busy  output  1  source must hold data_in

Behaviour:
- Reset (resetn=0 at posedge): state=DECODE_ADDRESS, addr_q=0.
  - Outputs after reset: detect_add=1, all other outputs 0 (busy=0).
- addr_q: 2-bit register, loads data_in[1:0] when state=DECODE_ADDRESS and pkt_valid=1.
  - Selects the soft_reset_x / fifo_empty_x used in later states.
  - In DECODE_ADDRESS, selection uses data_in[1:0] directly.
- Soft reset has priority over all transitions except resetn: if soft_reset_[addr_q]=1 in any state other than DECODE_ADDRESS, next state = DECODE_ADDRESS.
- Transitions:
  - DECODE_ADDRESS: pkt_valid & addr<3 & fifo_empty_[addr] -> LOAD_FIRST_DATA; pkt_valid & addr<3 & !fifo_empty_[addr] -> WAIT_TILL_EMPTY; otherwise (no pkt_valid or addr=3) stay.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally (exactly 1 cycle).
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full takes priority over !pkt_valid.
  - LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
  - FIFO_FULL_STATE: fifo_full -> stay; else LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
  - WAIT_TILL_EMPTY: fifo_empty_[addr_q] -> LOAD_FIRST_DATA; else stay.
- Outputs are Moore, decoded from the registered state, valid in the same cycle as the state:
  - detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in all states except DECODE_ADDRESS and LOAD_DATA.
- Invalid address 3: packet ignored, FSM remains in DECODE_ADDRESS, no write_enb_reg.
- Illegal state encodings recover to DECODE_ADDRESS next cycle.
- resetn mid-packet: immediate return to reset values at that edge, regardless of state.

Test Plan:
- Reset: resetn=0 two cycles, then 1 with pkt_valid=0 -> detect_add=1, busy=0, write_enb_reg=0; state holds DECODE_ADDRESS.
- 4-byte payload to port 1, all FIFOs empty: header data_in=01 with pkt_valid=1 -> next cycle lfd_state=1, busy=1; then ld_state=1, write_enb_reg=1 for 4 payload cycles; pkt_valid falls -> LOAD_PARITY (write_enb_reg=1, busy=1) -> rst_int_reg=1 one cycle -> detect_add=1.
- Full stall on port 0: fifo_full=1 in LOAD_DATA -> full_state=1, busy=1, write_enb_reg=0 until fifo_full=0 -> laf_state=1 one cycle. Then:
  - low_pkt_valid=0 -> ld_state.
  - Repeat with low_pkt_valid=1 -> LOAD_PARITY.
  - Repeat with parity_done=1 -> detect_add.
- Busy destination: fifo_empty_2=0, header 10 -> WAIT_TILL_EMPTY (busy=1) for 5 cycles; fifo_empty_2=1 -> lfd_state=1 next cycle.
- Invalid address 11 with pkt_valid=1 for 3 cycles -> detect_add stays 1, write_enb_reg and busy stay 0.
- Timeout: in WAIT_TILL_EMPTY for port 0, pulse soft_reset_0=1 -> detect_add=1 next cycle. Pulsing soft_reset_1 instead -> no effect.

Source files
------------

// File: rtl/router_fsm_if.sv
// Signal bundle between the router input side / synchronizer and the packet-reception FSM.
// Handshake: the source drives pkt_valid/data_in and must hold data_in while busy is high.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;
    logic [2:0] fsm_state;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
               rst_int_reg, busy, fsm_state
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
               rst_int_reg, busy, fsm_state
    );
endinterface

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router: address decode, header/payload/parity
// load sequencing, FIFO-full stalls and timeout (soft reset) recovery.
module router_fsm (
    input logic         clock,
    input logic         resetn,
    router_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        CHECK_PARITY_ERROR = 3'd4,
        FIFO_FULL_STATE    = 3'd5,
        LOAD_AFTER_FULL    = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] addr_q;
    logic [1:0] sel_addr;
    logic       sel_empty;
    logic       sel_soft;
    logic       detect_add_q, lfd_state_q, ld_state_q, laf_state_q, full_state_q;
    logic       write_enb_reg_q, rst_int_reg_q, busy_q;

    // The header byte is still on data_in during decode, so it selects directly there.
    always_comb begin
        sel_addr  = (state_q == DECODE_ADDRESS) ? bus.data_in : addr_q;
        sel_empty = 1'b0;
        sel_soft  = 1'b0;
        case (sel_addr)
            2'd0:    begin sel_empty = bus.fifo_empty_0; sel_soft = bus.soft_reset_0; end
            2'd1:    begin sel_empty = bus.fifo_empty_1; sel_soft = bus.soft_reset_1; end
            2'd2:    begin sel_empty = bus.fifo_empty_2; sel_soft = bus.soft_reset_2; end
            default: begin sel_empty = 1'b0;             sel_soft = 1'b0;             end
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (state_q != DECODE_ADDRESS && sel_soft) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (bus.pkt_valid && bus.data_in != 2'd3)
                        state_d = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA:    state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid) state_d = LOAD_PARITY;
                end
                LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                FIFO_FULL_STATE:    state_d = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)        state_d = DECODE_ADDRESS;
                    else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                    else                        state_d = LOAD_DATA;
                end
                WAIT_TILL_EMPTY:    state_d = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                default:            state_d = DECODE_ADDRESS;
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q         <= DECODE_ADDRESS;
            addr_q          <= 2'd0;
            detect_add_q    <= 1'b1;
            lfd_state_q     <= 1'b0;
            ld_state_q      <= 1'b0;
            laf_state_q     <= 1'b0;
            full_state_q    <= 1'b0;
            write_enb_reg_q <= 1'b0;
            rst_int_reg_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE_ADDRESS && bus.pkt_valid)
                addr_q <= bus.data_in;
            detect_add_q    <= (state_d == DECODE_ADDRESS);
            lfd_state_q     <= (state_d == LOAD_FIRST_DATA);
            ld_state_q      <= (state_d == LOAD_DATA);
            laf_state_q     <= (state_d == LOAD_AFTER_FULL);
            full_state_q    <= (state_d == FIFO_FULL_STATE);
            write_enb_reg_q <= (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) ||
                               (state_d == LOAD_AFTER_FULL);
            rst_int_reg_q   <= (state_d == CHECK_PARITY_ERROR);
            busy_q          <= (state_d != DECODE_ADDRESS) && (state_d != LOAD_DATA);
        end
    end

    assign bus.detect_add    = detect_add_q;
    assign bus.lfd_state     = lfd_state_q;
    assign bus.ld_state      = ld_state_q;
    assign bus.laf_state     = laf_state_q;
    assign bus.full_state    = full_state_q;
    assign bus.write_enb_reg = write_enb_reg_q;
    assign bus.rst_int_reg   = rst_int_reg_q;
    assign bus.busy          = busy_q;
    assign bus.fsm_state     = state_q;
endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed vector table for the packet scenarios, then random
// stimulus checked against a packet-phase model.
module tb_router_fsm;
  logic clock;
  logic resetn;
  router_fsm_if bus ();

  router_fsm dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // output order: detect_add lfd ld laf full_state write_enb rst_int busy
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_WTE = 8'b0000_0001;
  localparam logic [2:0] E     = 3'b111;

  typedef struct {
    logic       rstn;
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] emp;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mkv(input logic rstn, input logic pv, input logic [1:0] din,
                               input logic full, input logic [2:0] emp, input logic [2:0] sr,
                               input logic pd, input logic lpv, input logic [7:0] exp);
    vec_t v;
    v.rstn = rstn; v.pv = pv; v.din = din; v.full = full; v.emp = emp;
    v.sr = sr; v.pd = pd; v.lpv = lpv; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
            bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
  endfunction

  task automatic apply(input vec_t v);
    resetn            = v.rstn;
    bus.pkt_valid     = v.pv;
    bus.data_in       = v.din;
    bus.fifo_full     = v.full;
    bus.fifo_empty_0  = v.emp[0];
    bus.fifo_empty_1  = v.emp[1];
    bus.fifo_empty_2  = v.emp[2];
    bus.soft_reset_0  = v.sr[0];
    bus.soft_reset_1  = v.sr[1];
    bus.soft_reset_2  = v.sr[2];
    bus.parity_done   = v.pd;
    bus.low_pkt_valid = v.lpv;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b (detect,lfd,ld,laf,full,wen,rst_int,busy)",
               name, act, exp);
    end
  endtask

  // Reference model: packet phases named by role, transitions taken from the protocol rules.
  typedef enum int {P_IDLE, P_HEADER, P_PAYLOAD, P_PARITY, P_CHECK, P_STALL, P_RESUME, P_WAIT} phase_e;

  function automatic logic [7:0] phase_outs(input phase_e p);
    case (p)
      P_IDLE:    return O_DA;
      P_HEADER:  return O_LFD;
      P_PAYLOAD: return O_LD;
      P_PARITY:  return O_LP;
      P_CHECK:   return O_CPE;
      P_STALL:   return O_FFS;
      P_RESUME:  return O_LAF;
      default:   return O_WTE;
    endcase
  endfunction

  phase_e     m_phase;
  logic [1:0] m_port;

  task automatic model_step(input vec_t v);
    phase_e     nxt;
    logic [1:0] port;
    if (!v.rstn) begin
      m_phase = P_IDLE;
      m_port  = 2'd0;
      return;
    end
    port = (m_phase == P_IDLE) ? v.din : m_port;
    nxt  = m_phase;
    if (m_phase != P_IDLE && port != 2'd3 && v.sr[port]) nxt = P_IDLE;
    else if (m_phase == P_IDLE) begin
      if (v.pv && port != 2'd3) nxt = v.emp[port] ? P_HEADER : P_WAIT;
    end
    else if (m_phase == P_HEADER)  nxt = P_PAYLOAD;
    else if (m_phase == P_PAYLOAD) nxt = v.full ? P_STALL : (!v.pv ? P_PARITY : P_PAYLOAD);
    else if (m_phase == P_PARITY)  nxt = P_CHECK;
    else if (m_phase == P_CHECK)   nxt = v.full ? P_STALL : P_IDLE;
    else if (m_phase == P_STALL)   nxt = v.full ? P_STALL : P_RESUME;
    else if (m_phase == P_RESUME)  nxt = v.pd ? P_IDLE : (v.lpv ? P_PARITY : P_PAYLOAD);
    else if (m_phase == P_WAIT)    nxt = v.emp[port] ? P_HEADER : P_WAIT;
    if (m_phase == P_IDLE && v.pv) m_port = v.din;
    m_phase = nxt;
  endtask

  initial begin
    vec_t v;
    apply(mkv(0, 0, 0, 0, E, 0, 0, 0, O_DA));

    // reset, then 4-byte packet to port 1
    vecs.push_back(mkv(0, 0, 0, 0, E, 0, 0, 0, O_DA));
    vecs.push_back(mkv(0, 0, 0, 0, E, 0, 0, 0, O_DA));
    vecs.push_back(mkv(1, 0, 0, 0, E, 0, 0, 0, O_DA));
    vecs.push_back(mkv(1, 1, 1, 0, E, 0, 0, 0, O_LFD));
    for (int i = 0; i < 4; i++) vecs.push_back(mkv(1, 1, 1, 0, E, 0, 0, 0, O_LD));
    vecs.push_back(mkv(1, 0, 1, 0, E, 0, 0, 0, O_LP));
    vecs.push_back(mkv(1, 0, 0, 0, E, 0, 0, 0, O_CPE));
    vecs.push_back(mkv(1, 0, 0, 0, E, 0, 0, 0, O_DA));
    // full stall on port 0: resume to payload, then to parity
    vecs.push_back(mkv(1, 1, 0, 0, E, 0, 0, 0, O_LFD));
    vecs.push_back(mkv(1, 1, 0, 0, E, 0, 0, 0, O_LD));
    vecs.push_back(mkv(1, 1, 0, 1, E, 0, 0, 0, O_FFS));
    vecs.push_back(mkv(1, 1, 0, 1, E, 0, 0, 0, O_FFS));
    vecs.push_back(mkv(1, 1, 0, 0, E, 0, 0, 0, O_LAF));
    vecs.push_back(mkv(1, 1, 0, 0, E, 0, 0, 0, O_LD));
    vecs.push_back(mkv(1, 1, 0, 1, E, 0, 0, 0, O_FFS));
    vecs.push_back(mkv(1, 0, 0, 0, E, 0, 0, 0, O_LAF));
    vecs.push_back(mkv(1, 0, 0, 0, E, 0, 0, 1, O_LP));
    vecs.push_back(mkv(1, 0, 0, 0, E, 0, 0, 0, O_CPE));
    vecs.push_back(mkv(1, 0, 0, 0, E, 0, 0, 0, O_DA));
    // stall then parity_done
    vecs.push_back(mkv(1, 1, 0, 0, E, 0, 0, 0, O_LFD));
    vecs.push_back(mkv(1, 1, 0, 0, E, 0, 0, 0, O_LD));
    vecs.push_back(mkv(1, 1, 0, 1, E, 0, 0, 0, O_FFS));
    vecs.push_back(mkv(1, 0, 0, 0, E, 0, 0, 0, O_LAF));
    vecs.push_back(mkv(1, 0, 0, 0, E, 0, 1, 0, O_DA));
    // destination 2 not empty: wait 5 cycles
    for (int i = 0; i < 5; i++) vecs.push_back(mkv(1, 1, 2, 0, 3'b011, 0, 0, 0, O_WTE));
    vecs.push_back(mkv(1, 1, 2, 0, E, 0, 0, 0, O_LFD));
    vecs.push_back(mkv(1, 1, 2, 0, E, 0, 0, 0, O_LD));
    vecs.push_back(mkv(1, 0, 2, 0, E, 0, 0, 0, O_LP));
    vecs.push_back(mkv(1, 0, 0, 0, E, 0, 0, 0, O_CPE));
    vecs.push_back(mkv(1, 0, 0, 0, E, 0, 0, 0, O_DA));
    // invalid address 3
    for (int i = 0; i < 3; i++) vecs.push_back(mkv(1, 1, 3, 0, E, 0, 0, 0, O_DA));
    // timeout while waiting on port 0: wrong port ignored, own port aborts
    vecs.push_back(mkv(1, 1, 0, 0, 3'b110, 3'b000, 0, 0, O_WTE));
    vecs.push_back(mkv(1, 0, 0, 0, 3'b110, 3'b010, 0, 0, O_WTE));
    vecs.push_back(mkv(1, 0, 0, 0, 3'b110, 3'b001, 0, 0, O_DA));
    // resetn mid-packet
    vecs.push_back(mkv(1, 1, 1, 0, E, 0, 0, 0, O_LFD));
    vecs.push_back(mkv(1, 1, 1, 0, E, 0, 0, 0, O_LD));
    vecs.push_back(mkv(0, 1, 1, 0, E, 0, 0, 0, O_DA));
    // full seen in CHECK_PARITY_ERROR
    vecs.push_back(mkv(1, 1, 1, 0, E, 0, 0, 0, O_LFD));
    vecs.push_back(mkv(1, 1, 1, 0, E, 0, 0, 0, O_LD));
    vecs.push_back(mkv(1, 0, 1, 0, E, 0, 0, 0, O_LP));
    vecs.push_back(mkv(1, 0, 1, 1, E, 0, 0, 0, O_CPE));
    vecs.push_back(mkv(1, 0, 1, 1, E, 0, 0, 0, O_FFS));
    vecs.push_back(mkv(1, 0, 1, 0, E, 0, 0, 0, O_LAF));
    vecs.push_back(mkv(1, 0, 1, 0, E, 0, 1, 0, O_DA));
    // soft reset while loading payload on port 2
    vecs.push_back(mkv(1, 1, 2, 0, E, 0, 0, 0, O_LFD));
    vecs.push_back(mkv(1, 1, 2, 0, E, 0, 0, 0, O_LD));
    vecs.push_back(mkv(1, 1, 2, 0, E, 3'b100, 0, 0, O_DA));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      apply(vecs[i]);
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // random phase: model starts from a forced reset
    m_phase = P_IDLE;
    m_port  = 2'd0;
    @(negedge clock);
    apply(mkv(0, 0, 0, 0, E, 0, 0, 0, O_DA));
    @(posedge clock);
    #1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      v = mkv($urandom_range(0, 99) != 0,
              $urandom_range(0, 9) < 7,
              2'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0,
              {$urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7},
              {$urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0},
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 2) == 0,
              8'h00);
      apply(v);
      model_step(v);
      @(posedge clock);
      #1;
      chk($sformatf("rnd%0d", i), outs(), phase_outs(m_phase));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
